data_memory_responder: RTL and testbench
========================================

// Module: data_memory_responder
// PURPOSE
// - Responder side of the processor data-memory bus (Daddress/Dout/W out of the core, DataIn back in).
// - Single-port DEPTH x 20-bit word RAM. Serves one read or write per request, with a programmable
//   number of wait states. Handshake is Req/Ready; Busy marks an access in flight.
// - Sits beside pipelineProcessor as its data memory; the MEM stage holds Req until Ready.
// PARAMETERS
// - DATA_W       20   word width; must match the processor datapath
// - ADDR_W       8    RAM index width; DEPTH = 2**ADDR_W words
// - WAIT_STATES  1    extra cycles between accept and Ready; legal range 0..15
// PORTS
// - Clock     in   1       rising-edge clock
// - Reset     in   1       asynchronous, active-low reset
// - Req       in   1       access request; sampled only in IDLE
// - Daddress  in   20      word address from the processor
// - Dout      in   20      write data from the processor
// - W         in   1       1 = write, 0 = read; sampled with Req
// - DataIn    out  20      read data to the processor; valid while Ready=1, held until the next read completes
// - Ready     out  1       one-cycle completion pulse, for both read and write
// - Busy      out  1       1 while state != IDLE
// - AddrErr   out  1       out-of-range flag; present only with ADDR_CHECK_EN, otherwise tied to 0
// BEHAVIOUR
// - Reset (Reset=0, async): state=IDLE, wait counter=0, Ready=0, Busy=0, DataIn=0, AddrErr=0.
//   Latched address, data and W are discarded, and a pending write is never committed.
//   RAM contents are not cleared and are retained across reset.
// - FSM states: IDLE, WAIT, RESP.
//   - IDLE: Req=1 at edge k latches Daddress[ADDR_W-1:0], Dout and W.
//     Go to WAIT with counter=WAIT_STATES-1, or go straight to RESP if WAIT_STATES=0.
//   - WAIT: counter decrements each cycle; at counter=0, go to RESP.
//   - RESP: Ready=1 for exactly one cycle, then go to IDLE unconditionally.
// - Latency: Ready is high in cycle k+1+WAIT_STATES. Throughput is one access per WAIT_STATES+2 cycles.
// - Commit: a write updates the RAM on the edge that enters RESP. A read loads DataIn on that same edge.
// - Writes leave DataIn unchanged.
// - Req while Busy=1, including the RESP cycle, is ignored. Nothing is queued and no error is flagged.
//   A Req held high through RESP is re-accepted in the following IDLE cycle.
// - Daddress, Dout and W may change after accept without affecting the access in flight.
// - A read of a word never written returns the RAM power-up value; the bench must write before reading.
// - A read immediately after a write to the same address returns the new data. No bypass is needed:
//   the write commits before the next access is accepted.
// - Without ADDR_CHECK_EN, Daddress[19:ADDR_W] is ignored and the address aliases modulo DEPTH.
// CONFIGURATION
// - Macro ADDR_CHECK_EN.
// - Defined: an access with Daddress[19:ADDR_W] != 0 completes with normal timing, and AddrErr=1
//   together with Ready. The write is suppressed and a read drives DataIn=0. AddrErr=0 at all other times.
// - Undefined: no range check; AddrErr is constant 0 and addresses alias as described above.
// TESTING
// - WAIT_STATES=1: write 0xABCDE to addr 0x05, then read 0x05.
//   -> Ready in cycle k+2 for each access; DataIn=0xABCDE on the read's Ready cycle.
// - WAIT_STATES=0: back-to-back reads with Req held high.
//   -> Ready every 2nd cycle; Busy toggles 1/0; each DataIn matches the RAM word.
// - Req pulses during WAIT and RESP.
//   -> They are ignored: exactly one Ready per accepted request, and no extra writes in the RAM.
// - Reset=0 asserted mid-WAIT of a write of 0x12345 to addr 0x10.
//   -> Ready, Busy and DataIn go to 0 immediately; a later read of 0x10 returns the old value.
// - Addr 0x00105 vs 0x00005 (ADDR_W=8).
//   -> Without the macro, both hit the same word.
//   -> With ADDR_CHECK_EN, a write to 0x00105 sets AddrErr=1 with Ready and leaves 0x05 unchanged;
//      a read of 0x00105 gives DataIn=0.
// - WAIT_STATES=15: a single read.
//   -> Ready exactly 16 cycles after the accept edge; Busy high for 16 cycles.

Source files
------------

// File: rtl/data_memory_responder.sv
// data_memory_responder
// Responder for the processor data-memory bus: a DEPTH x DATA_W single-port RAM
// serving one read or write per Req/Ready handshake after WAIT_STATES extra cycles.
// Optional feature macro: ADDR_CHECK_EN (flags and suppresses out-of-range accesses).
module data_memory_responder #(
   parameter int DATA_W      = 20,
   parameter int ADDR_W      = 8,
   parameter int WAIT_STATES = 1
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Req,
   input  logic [DATA_W-1:0] Daddress,
   input  logic [DATA_W-1:0] Dout,
   input  logic              W,
   output logic [DATA_W-1:0] DataIn,
   output logic              Ready,
   output logic              Busy,
   output logic              AddrErr
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [3:0] CNT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic [3:0]          r_cnt;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_data;
   logic                r_we;
   logic                r_err;
   logic [DATA_W-1:0]   r_mem [DEPTH];

   logic                w_accept;
   logic                w_commit;
   logic [ADDR_W-1:0]   w_c_addr;
   logic [DATA_W-1:0]   w_c_data;
   logic                w_c_we;
   logic                w_c_err;
   logic                w_in_err;

`ifdef ADDR_CHECK_EN
   assign w_in_err = |Daddress[DATA_W-1:ADDR_W];
   assign AddrErr  = (r_state == ST_RESP) && r_err;
`else
   logic w_unused_hi;
   assign w_unused_hi = ^Daddress[DATA_W-1:ADDR_W];
   assign w_in_err    = 1'b0;
   assign AddrErr     = 1'b0;
`endif

   assign Ready = (r_state == ST_RESP);
   assign Busy  = (r_state != ST_IDLE);

   // Next-state decode plus accept/commit strobes
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (Req) begin
               w_accept     = 1'b1;
               w_next_state = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (r_cnt == 4'd0) w_next_state = ST_RESP;
         end
         ST_RESP: w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
      w_commit = (w_next_state == ST_RESP) && (r_state != ST_RESP);
   end

   // With zero wait states the access commits on its accept edge, so it must
   // take address/data straight from the bus instead of the latched copies.
   always_comb begin
      if (r_state == ST_IDLE) begin
         w_c_addr = Daddress[ADDR_W-1:0];
         w_c_data = Dout;
         w_c_we   = W;
         w_c_err  = w_in_err;
      end else begin
         w_c_addr = r_addr;
         w_c_data = r_data;
         w_c_we   = r_we;
         w_c_err  = r_err;
      end
   end

   // State, wait counter, request latch and read-data register
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_data  <= '0;
         r_we    <= 1'b0;
         r_err   <= 1'b0;
         DataIn  <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_accept) begin
            r_cnt  <= CNT_INIT;
            r_addr <= Daddress[ADDR_W-1:0];
            r_data <= Dout;
            r_we   <= W;
            r_err  <= w_in_err;
         end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_commit && !w_c_we) begin
            DataIn <= w_c_err ? '0 : r_mem[w_c_addr];
         end
      end
   end

   // RAM write port; contents survive reset, and no write lands while reset is held
   always_ff @(posedge Clock) begin
      if (Reset && w_commit && w_c_we && !w_c_err) begin
         r_mem[w_c_addr] <= w_c_data;
      end
   end

endmodule

// File: tb/tb_data_memory_responder.sv
// Testbench for data_memory_responder: three instances (WAIT_STATES = 1, 0, 15)
// checked against an array-based memory model and the Ready = accept + WS + 1 rule.
module tb_data_memory_responder;

`ifdef ADDR_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        req  [3];
   logic        w    [3];
   logic [19:0] addr [3];
   logic [19:0] dout [3];
   logic [19:0] din  [3];
   logic        rdy  [3];
   logic        bsy  [3];
   logic        aerr [3];

   int total = 0;
   int bad   = 0;

   logic [19:0] mdl     [3][256];
   logic [19:0] last_rd [3];

   data_memory_responder #(.DATA_W(20), .ADDR_W(8), .WAIT_STATES(1)) u_ws1 (
      .Clock(clk), .Reset(rst_n), .Req(req[0]), .Daddress(addr[0]), .Dout(dout[0]), .W(w[0]),
      .DataIn(din[0]), .Ready(rdy[0]), .Busy(bsy[0]), .AddrErr(aerr[0]));
   data_memory_responder #(.DATA_W(20), .ADDR_W(8), .WAIT_STATES(0)) u_ws0 (
      .Clock(clk), .Reset(rst_n), .Req(req[1]), .Daddress(addr[1]), .Dout(dout[1]), .W(w[1]),
      .DataIn(din[1]), .Ready(rdy[1]), .Busy(bsy[1]), .AddrErr(aerr[1]));
   data_memory_responder #(.DATA_W(20), .ADDR_W(8), .WAIT_STATES(15)) u_ws15 (
      .Clock(clk), .Reset(rst_n), .Req(req[2]), .Daddress(addr[2]), .Dout(dout[2]), .W(w[2]),
      .DataIn(din[2]), .Ready(rdy[2]), .Busy(bsy[2]), .AddrErr(aerr[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int ws_of(input int sel);
      case (sel)
         0: return 1;
         1: return 0;
         default: return 15;
      endcase
   endfunction

   function automatic logic exp_err(input logic [19:0] a);
      return CHK && (a[19:8] != 12'h0);
   endfunction

   // Drives one access starting at a negedge in IDLE; returns at a negedge in IDLE.
   task automatic do_access(input int sel, input logic [19:0] a, input logic [19:0] d,
                            input logic wr, output logic [19:0] rd, output int lat,
                            output logic er, output int bc, output logic to);
      addr[sel] = a; dout[sel] = d; w[sel] = wr; req[sel] = 1'b1;
      @(posedge clk);
      #1;
      req[sel] = 1'b0;
      addr[sel] = 20'($urandom); dout[sel] = 20'($urandom); w[sel] = 1'($urandom);
      lat = 0; bc = 0; to = 1'b1; rd = '0; er = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (bsy[sel]) bc++;
         if (rdy[sel]) begin
            lat = i; rd = din[sel]; er = aerr[sel]; to = 1'b0;
            break;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         total++; if (rdy[s]  !== 1'b0) begin bad++; $display("FAIL reset_ready[%0d]: got %b want 0", s, rdy[s]); end
         total++; if (bsy[s]  !== 1'b0) begin bad++; $display("FAIL reset_busy[%0d]: got %b want 0", s, bsy[s]); end
         total++; if (din[s]  !== 20'h0) begin bad++; $display("FAIL reset_datain[%0d]: got %h want 0", s, din[s]); end
         total++; if (aerr[s] !== 1'b0) begin bad++; $display("FAIL reset_addrerr[%0d]: got %b want 0", s, aerr[s]); end
         last_rd[s] = '0;
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_write_read();
      logic [19:0] rd; int lat; logic er; int bc; logic to;
      do_access(0, 20'h00005, 20'hABCDE, 1'b1, rd, lat, er, bc, to);
      mdl[0][8'h05] = 20'hABCDE;
      total++; if (to || lat != 2) begin bad++; $display("FAIL wr_latency: got %0d want 2", lat); end
      do_access(0, 20'h00005, 20'h0, 1'b0, rd, lat, er, bc, to);
      total++; if (to || lat != 2) begin bad++; $display("FAIL rd_latency: got %0d want 2", lat); end
      total++; if (rd !== 20'hABCDE) begin bad++; $display("FAIL rd_data: got %h want abcde", rd); end
      last_rd[0] = 20'hABCDE;
   endtask

   task automatic test_random(input int sel, input int n);
      logic [19:0] rd; int lat; logic er; int bc; logic to;
      logic [19:0] a; logic [19:0] d; logic wr; logic [19:0] exp;
      int unsigned wl[$];
      for (int i = 0; i < n; i++) begin
         wr = (wl.size() == 0) ? 1'b1 : 1'($urandom);
         d  = 20'($urandom);
         if (wr) a = {(($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'h0), 8'($urandom)};
         else    a = {(($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'h0),
                      8'(wl[$urandom_range(0, wl.size() - 1)])};
         do_access(sel, a, d, wr, rd, lat, er, bc, to);
         total++;
         if (to || lat != ws_of(sel) + 1) begin
            bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", sel, lat, ws_of(sel) + 1);
         end
         total++;
         if (er !== exp_err(a)) begin
            bad++; $display("FAIL rand_addrerr[%0d] addr %h: got %b want %b", sel, a, er, exp_err(a));
         end
         if (wr) begin
            total++;
            if (rd !== last_rd[sel]) begin
               bad++; $display("FAIL rand_wr_holds_datain[%0d]: got %h want %h", sel, rd, last_rd[sel]);
            end
            if (!exp_err(a)) begin
               mdl[sel][a[7:0]] = d;
               wl.push_back(int'(a[7:0]));
            end
         end else begin
            exp = exp_err(a) ? 20'h0 : mdl[sel][a[7:0]];
            total++;
            if (rd !== exp) begin
               bad++; $display("FAIL rand_rd_data[%0d] addr %h: got %h want %h", sel, a, rd, exp);
            end
            last_rd[sel] = exp;
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [19:0] rd; int lat; logic er; int bc; logic to;
      logic [7:0] lst [8];
      for (int i = 0; i < 8; i++) begin
         lst[i] = 8'(8'h40 + 8'(i * 3));
         rd = 20'($urandom);
         do_access(1, {12'h0, lst[i]}, rd, 1'b1, rd, lat, er, bc, to);
         mdl[1][lst[i]] = dout[1];
      end
      // the write data was re-randomized after accept, so reload the model from a fresh pass
      for (int i = 0; i < 8; i++) begin
         rd = 20'($urandom);
         mdl[1][lst[i]] = rd;
         do_access(1, {12'h0, lst[i]}, rd, 1'b1, rd, lat, er, bc, to);
      end
      w[1] = 1'b0; req[1] = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (i > 0) @(negedge clk);
         total++;
         if (bsy[1] !== 1'(i % 2) || rdy[1] !== 1'(i % 2)) begin
            bad++; $display("FAIL b2b_busy_ready[%0d]: got %b/%b want %0d", i, bsy[1], rdy[1], i % 2);
         end
         if (i % 2 == 0) begin
            addr[1] = {12'h0, lst[i / 2]};
         end else begin
            total++;
            if (din[1] !== mdl[1][lst[i / 2]]) begin
               bad++; $display("FAIL b2b_data[%0d]: got %h want %h", i / 2, din[1], mdl[1][lst[i / 2]]);
            end
         end
      end
      @(negedge clk);
      req[1] = 1'b0;
      last_rd[1] = mdl[1][lst[7]];
      @(negedge clk);
   endtask

   task automatic test_req_during_busy();
      logic [19:0] rd; int lat; logic er; int bc; logic to;
      int nrdy;
      do_access(0, 20'h00021, 20'h11111, 1'b1, rd, lat, er, bc, to);
      mdl[0][8'h21] = 20'h11111;
      addr[0] = 20'h00020; dout[0] = 20'h22222; w[0] = 1'b1; req[0] = 1'b1;
      @(posedge clk);
      #1;
      req[0] = 1'b0;
      mdl[0][8'h20] = 20'h22222;
      nrdy = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (rdy[0]) nrdy++;
         if (bsy[0]) begin
            req[0] = 1'b1; w[0] = 1'b1; addr[0] = 20'h00021; dout[0] = 20'($urandom);
         end else begin
            req[0] = 1'b0;
            break;
         end
      end
      repeat (5) begin
         @(negedge clk);
         if (rdy[0]) nrdy++;
      end
      total++;
      if (nrdy != 1) begin bad++; $display("FAIL busy_req_ready_count: got %0d want 1", nrdy); end
      do_access(0, 20'h00021, 20'h0, 1'b0, rd, lat, er, bc, to);
      total++;
      if (rd !== 20'h11111) begin bad++; $display("FAIL busy_req_no_write: got %h want 11111", rd); end
      do_access(0, 20'h00020, 20'h0, 1'b0, rd, lat, er, bc, to);
      total++;
      if (rd !== 20'h22222) begin bad++; $display("FAIL busy_req_accepted_write: got %h want 22222", rd); end
      last_rd[0] = rd;
   endtask

   task automatic test_reset_mid_wait();
      logic [19:0] rd; int lat; logic er; int bc; logic to;
      do_access(0, 20'h00010, 20'h0F0F0, 1'b1, rd, lat, er, bc, to);
      do_access(0, 20'h00010, 20'h0, 1'b0, rd, lat, er, bc, to);
      addr[0] = 20'h00010; dout[0] = 20'h12345; w[0] = 1'b1; req[0] = 1'b1;
      @(posedge clk);
      #1;
      req[0] = 1'b0;
      @(negedge clk);
      total++;
      if (bsy[0] !== 1'b1 || din[0] !== 20'h0F0F0) begin
         bad++; $display("FAIL midwait_pre: got busy=%b data=%h want 1/0f0f0", bsy[0], din[0]);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (rdy[0] !== 1'b0 || bsy[0] !== 1'b0 || din[0] !== 20'h0) begin
         bad++; $display("FAIL midwait_reset: got %b/%b/%h want 0/0/0", rdy[0], bsy[0], din[0]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int s = 0; s < 3; s++) last_rd[s] = '0;
      @(negedge clk);
      do_access(0, 20'h00010, 20'h0, 1'b0, rd, lat, er, bc, to);
      total++;
      if (rd !== 20'h0F0F0 || lat != 2) begin
         bad++; $display("FAIL midwait_old_value: got %h lat %0d want 0f0f0 lat 2", rd, lat);
      end
      last_rd[0] = rd;
   endtask

   task automatic test_alias();
      logic [19:0] rd; int lat; logic er; int bc; logic to;
      logic [19:0] exp;
      do_access(0, 20'h00005, 20'h55AA5, 1'b1, rd, lat, er, bc, to);
      total++;
      if (er !== 1'b0) begin bad++; $display("FAIL alias_wr_inrange_err: got %b want 0", er); end
      mdl[0][8'h05] = 20'h55AA5;
      do_access(0, 20'h00105, 20'h3C3C3, 1'b1, rd, lat, er, bc, to);
      total++;
      if (er !== CHK || lat != 2) begin
         bad++; $display("FAIL alias_wr_err: got %b lat %0d want %b lat 2", er, lat, CHK);
      end
      if (!CHK) mdl[0][8'h05] = 20'h3C3C3;
      do_access(0, 20'h00005, 20'h0, 1'b0, rd, lat, er, bc, to);
      total++;
      if (rd !== mdl[0][8'h05]) begin bad++; $display("FAIL alias_rd_low: got %h want %h", rd, mdl[0][8'h05]); end
      do_access(0, 20'h00105, 20'h0, 1'b0, rd, lat, er, bc, to);
      exp = CHK ? 20'h0 : mdl[0][8'h05];
      total++;
      if (rd !== exp || er !== CHK) begin
         bad++; $display("FAIL alias_rd_high: got %h err %b want %h err %b", rd, er, exp, CHK);
      end
      last_rd[0] = exp;
   endtask

   task automatic test_long_wait();
      logic [19:0] rd; int lat; logic er; int bc; logic to;
      do_access(2, 20'h00033, 20'h7E7E7, 1'b1, rd, lat, er, bc, to);
      do_access(2, 20'h00033, 20'h0, 1'b0, rd, lat, er, bc, to);
      total++;
      if (to || lat != 16) begin bad++; $display("FAIL ws15_latency: got %0d want 16", lat); end
      total++;
      if (bc != 16) begin bad++; $display("FAIL ws15_busy_cycles: got %0d want 16", bc); end
      total++;
      if (rd !== 20'h7E7E7) begin bad++; $display("FAIL ws15_data: got %h want 7e7e7", rd); end
      last_rd[2] = rd;
   endtask

   initial begin
      rst_n = 1'b0;
      for (int s = 0; s < 3; s++) begin
         req[s] = 1'b0; w[s] = 1'b0; addr[s] = '0; dout[s] = '0; last_rd[s] = '0;
      end
      @(negedge clk);
      test_reset();
      test_write_read();
      test_random(0, 24);
      test_random(1, 24);
      test_random(2, 10);
      test_back_to_back();
      test_req_during_busy();
      test_reset_mid_wait();
      test_alias();
      test_long_wait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
